// File: rtl/div_fx_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits. Purely combinational.
module div_fx_step #(
  parameter int NUBITS = 32
) (
  input  logic [NUBITS:0]   rem_i,
  input  logic              dvd_bit_i,
  input  logic [NUBITS-1:0] dvs_i,
  output logic [NUBITS:0]   rem_o,
  output logic              q_bit_o
);

  logic [NUBITS+1:0] shifted;
  logic [NUBITS+1:0] diff;

  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    diff    = shifted - {2'b00, dvs_i};
    q_bit_o = ~diff[NUBITS+1];
    rem_o   = q_bit_o ? diff[NUBITS:0] : shifted[NUBITS:0];
  end

endmodule

// File: rtl/div_fx_seq.sv
// Sequential signed divider: NUBITS restoring steps on magnitudes, then a
// sign-fix cycle that produces the quotient or remainder.
module div_fx_seq #(
  parameter int NUBITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_mod,
  input  logic [NUBITS-1:0] in1,
  input  logic [NUBITS-1:0] in2,
  output logic              busy,
  output logic              done,
  output logic [NUBITS-1:0] out,
  output logic              is_zero,
  output logic              dbz
);

  localparam int CW = $clog2(NUBITS) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NUBITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NUBITS:0]   rem_q, rem_d, step_rem;
  logic [NUBITS-1:0] quo_q, quo_d;
  logic [NUBITS-1:0] dvs_q, dvs_d;
  logic [NUBITS-1:0] out_q, out_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mod_q, mod_d;
  logic              neg1_q, neg1_d;
  logic              neg2_q, neg2_d;
  logic              zdiv_q, zdiv_d;
  logic              dbz_q, dbz_d;
  logic              done_q, done_d;
  logic              step_q_bit;
  logic [NUBITS-1:0] quo_signed, rem_signed;

  div_fx_step #(.NUBITS(NUBITS)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (quo_q[NUBITS-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  // With a zero divisor the dividend magnitude is still unshifted in quo_q.
  always_comb begin
    quo_signed = zdiv_q ? '0 : ((neg1_q ^ neg2_q) ? -quo_q : quo_q);
    rem_signed = zdiv_q ? (neg1_q ? -quo_q : quo_q)
                        : (neg1_q ? -rem_q[NUBITS-1:0] : rem_q[NUBITS-1:0]);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;
    zdiv_d  = zdiv_q;
    out_d   = out_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mod_d   = op_mod;
          neg1_d  = in1[NUBITS-1];
          neg2_d  = in2[NUBITS-1];
          quo_d   = in1[NUBITS-1] ? -in1 : in1;
          dvs_d   = in2[NUBITS-1] ? -in2 : in2;
          rem_d   = '0;
          cnt_d   = '0;
          zdiv_d  = (in2 == '0);
          state_d = (in2 == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[NUBITS-2:0], step_q_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        out_d   = mod_q ? rem_signed : quo_signed;
        dbz_d   = zdiv_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  // NOTE: working registers are deliberately not reset; they are always
  // reloaded on start before anything reads them.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    cnt_q  <= cnt_d;
    mod_q  <= mod_d;
    neg1_q <= neg1_d;
    neg2_q <= neg2_d;
    zdiv_q <= zdiv_d;
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign out     = out_q;
  assign dbz     = dbz_q;
  assign is_zero = (out_q == '0);

endmodule

// File: tb/tb_div_fx_seq.sv
// Scoreboard bench for div_fx_seq: stimulus pushes expected results computed
// with plain signed arithmetic; a monitor checks every done pulse.
module tb_div_fx_seq;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst, start, op_mod;
  logic [N-1:0] in1, in2;
  logic         busy, done, is_zero, dbz;
  logic [N-1:0] out;

  typedef struct {
    logic [N-1:0] out;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   last_t0 = 0;

  div_fx_seq #(.NUBITS(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_mod  (op_mod),
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done),
    .out     (out),
    .is_zero (is_zero),
    .dbz     (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic m, output logic [N-1:0] o, output logic d);
    longint sa, sd, q, r;
    sa = longint'(signed'(a));
    sd = longint'(signed'(b));
    if (sd == 0) begin
      d = 1'b1;
      o = m ? a : '0;
    end else begin
      d = 1'b0;
      q = sa / sd;
      r = sa % sd;
      o = m ? r[N-1:0] : q[N-1:0];
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no operation pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out", out, e.out);
        check("dbz", dbz, e.dbz);
        check("is_zero", is_zero, (e.out == '0));
        check("latency", cyc, e.cyc);
        check("busy_in_done", busy, 1'b0);
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", k);
    end
  endtask

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic m);
    logic [N-1:0] o;
    logic         d;
    wait_idle();
    in1 = a; in2 = b; op_mod = m; start = 1'b1;
    @(posedge clk);
    #1;
    last_t0 = cyc;
    ref_model(a, b, m, o, d);
    sb.push_back('{o, d, cyc + ((b == '0) ? 1 : N + 1)});
    start = 1'b0;
    in1 = $urandom; in2 = $urandom; op_mod = 1'($urandom);
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 5))
      0: return N'($urandom_range(0, 20));
      1: return -N'($urandom_range(1, 20));
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t_first, snap, k;
    rst = 1'b1; start = 1'b0; op_mod = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out", out, 0);
    check("rst_is_zero", is_zero, 1'b1);
    check("rst_dbz", dbz, 1'b0);

    // 100/7 with busy held through the whole operation.
    do_op(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < N + 1; i++) begin
      @(negedge clk);
      check("busy_running", busy, 1'b1);
      check("done_early", done, 1'b0);
    end
    @(negedge clk);
    check("done_at_33", done, 1'b1);

    do_op(-32'sd100, 32'd7, 1'b1);
    do_op(32'd100, -32'sd7, 1'b0);
    do_op(32'd7, 32'd100, 1'b0);
    wait_idle();
    check("is_zero_7_100", is_zero, 1'b1);

    do_op(32'd55, 32'd0, 1'b0);
    do_op(32'd55, 32'd0, 1'b1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // Start while busy is ignored; start in the done cycle is accepted.
    do_op(32'd100, 32'd7, 1'b0);
    t_first = last_t0;
    repeat (5) @(negedge clk);
    in1 = 32'd9; in2 = 32'd3; op_mod = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    do_op(32'd9, 32'd3, 1'b0);
    check("b2b_start_edge", last_t0, t_first + N + 2);

    // Reset mid-operation abandons it.
    do_op(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_out", out, 0);
    check("midrst_is_zero", is_zero, 1'b1);
    check("midrst_dbz", dbz, 1'b0);

    // Start coincident with reset is ignored.
    rst = 1'b1; start = 1'b1; in1 = 32'd9; in2 = 32'd3;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", busy, 1'b0);
    snap = n_done;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", n_done, snap);

    for (int i = 0; i < 60; i++) begin
      do_op(pick(), pick(), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results never arrived", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_fx_seq.md
DIV_FX_SEQ -- requirements
Module: div_fx_seq

Interface
REQ-001 Parameter NUBITS, default 32, operand and result width in bits (two's complement).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only while idle.
REQ-005 op_mod  input  1  0 = quotient (DIV), 1 = remainder (MOD); captured with start.
REQ-006 in1  input  NUBITS  signed dividend; captured with start.
REQ-007 in2  input  NUBITS  signed divisor; captured with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; out is valid from that cycle on.
REQ-010 out  output  NUBITS  signed result, held until the next completion.
REQ-011 is_zero  output  1  high when out equals all zeros.
REQ-012 dbz  output  1  divide-by-zero flag for the last completed operation; held with out.

Function
REQ-013 The block SHALL have states IDLE, CALC and FIX; busy SHALL be high exactly when the state is not IDLE.
REQ-014 In IDLE, start=1 at edge t0 SHALL capture op_mod, the operand signs, |in1| and |in2| (unsigned, NUBITS bits); the next state SHALL be CALC, or FIX if in2 == 0.
REQ-015 CALC SHALL do one restoring shift/subtract step per cycle, MSB first, for exactly NUBITS cycles, then go to FIX.
REQ-016 FIX SHALL load out, dbz and done=1 in one cycle and return to IDLE; nonzero divisor: done high in the cycle after edge t0+NUBITS+1.
REQ-017 Quotient sign SHALL be sign(in1) XOR sign(in2), truncating toward zero; remainder sign SHALL follow in1, so in1 == q*in2 + r.
REQ-018 Divisor 0 SHALL skip CALC, set dbz=1, and return quotient 0 and remainder in1; done high in the cycle after edge t0+1.
REQ-019 Most-negative / -1 SHALL give quotient equal to the most-negative value (wrap) and remainder 0, with dbz=0.
REQ-020 done SHALL be low in every cycle other than the single FIX completion cycle.
REQ-021 start while busy SHALL be ignored with no effect on the running operation; held inputs need not be stable after t0.
REQ-022 start during the done cycle (state IDLE) SHALL be accepted, giving back-to-back operations with no idle gap.
REQ-023 is_zero SHALL be combinational from the registered out.

Reset
REQ-024 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, dbz=0 and out=0 (is_zero=1), including mid-operation, abandoning the operation.
REQ-025 start sampled at the same edge as rst=1 SHALL be ignored.

Structure
REQ-026 No shared package; state encoding SHALL be local constants; the ALU opcode numbering (DIV=4, MOD=5) stays owned by the ALU output mux and is not duplicated here.
REQ-027 One combinational sub-module, div_fx_step, SHALL implement a single restoring step (partial remainder, divisor -> next remainder, quotient bit), instantiated once.
REQ-028 Working registers: partial remainder NUBITS+1 bits, quotient/dividend shift register NUBITS bits, step counter clog2(NUBITS)+1 bits.

Verification (NUBITS=32)
REQ-029 in1=100, in2=7, op_mod=0 -> out=14, dbz=0; done exactly 33 edges after the start edge (cycle after t0+33), busy high throughout.
REQ-030 in1=-100, in2=7, op_mod=1 -> out=-2; in1=100, in2=-7, op_mod=0 -> out=-14; in1=7, in2=100, op_mod=0 -> out=0, is_zero=1.
REQ-031 in1=55, in2=0: op_mod=0 -> out=0, dbz=1; op_mod=1 -> out=55, dbz=1; done in the cycle after t0+1.
REQ-032 in1=0x80000000, in2=-1, op_mod=0 -> out=0x80000000, dbz=0; op_mod=1 -> out=0.
REQ-033 Start 100/7, pulse start with 9/3 at cycle 5 -> ignored, out=14; start 9/3 during the done cycle -> accepted, out=3 after 33 more edges.
REQ-034 rst at cycle 10 of an operation -> next cycle busy=0, done=0, out=0, is_zero=1, dbz=0; no done pulse afterward until a new start.
